// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared widths, wait bound and FSM encoding for the data memory responder
package dmem_responder_pkg;

   localparam int DMEM_ADDR_W_DEF = 10;
   localparam int DMEM_DATA_W_DEF = 32;
   localparam int DMEM_WAIT_MAX   = 15;
   localparam int DMEM_CNT_W      = 4;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_WAIT   = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;
   localparam logic [1:0] ST_ACK    = 2'd3;

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - 2^ADDR_W x DATA_W storage, synchronous write, registered read
module dmem_ram
   import dmem_responder_pkg::*;
#(
   parameter int ADDR_W = DMEM_ADDR_W_DEF,
   parameter int DATA_W = DMEM_DATA_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              we_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   logic [DATA_W-1:0] rdata_q;

   // Array has no reset so contents survive rst; only the read register clears.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - request FSM with wait-state counter and input latches in front of dmem_ram
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int ADDR_W      = DMEM_ADDR_W_DEF,
   parameter int DATA_W      = DMEM_DATA_W_DEF,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              cs,
   input  logic              we,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              ack,
   output logic              err,
   output logic              busy
);

   localparam logic [DMEM_CNT_W-1:0] WAIT_LD =
      DMEM_CNT_W'((WAIT_CYCLES > DMEM_WAIT_MAX) ? DMEM_WAIT_MAX : WAIT_CYCLES);
   localparam logic [DMEM_CNT_W-1:0] CNT_ONE = DMEM_CNT_W'(1);

   logic [1:0]            state_q, state_d;
   logic [DMEM_CNT_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [DATA_W-1:0]     wdata_q, wdata_d;
   logic                  we_q, we_d;
   logic                  err_q, err_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               addr_d  = address;
               wdata_d = data_in;
               we_d    = we;
               err_d   = !cs;
               if (!cs) begin
                  state_d = ST_ACK;
               end else if (WAIT_LD == '0) begin
                  state_d = ST_ACCESS;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_LD;
               end
            end
         end
         ST_WAIT: begin
            // A zero count here is unreachable but must not wedge the FSM.
            if (cnt_q <= CNT_ONE) begin
               cnt_d   = '0;
               state_d = ST_ACCESS;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_ACCESS: state_d = ST_ACK;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         err_q   <= err_d;
      end
   end

   dmem_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk_i   (clk),
      .rst_i   (rst),
      .we_i    ((state_q == ST_ACCESS) && we_q),
      .re_i    ((state_q == ST_ACCESS) && !we_q),
      .addr_i  (addr_q),
      .wdata_i (wdata_q),
      .rdata_o (data_out)
   );

   assign ack  = (state_q == ST_ACK);
   assign err  = (state_q == ST_ACK) && err_q;
   assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder (WAIT_CYCLES 1 and 0)
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic        cs = 1'b0;
   logic        we = 1'b0;
   logic [9:0]  address = '0;
   logic [31:0] data_in = '0;

   logic [31:0] data_out1, data_out0;
   logic        ack1, err1, busy1;
   logic        ack0, err0, busy0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dmem_responder #(.ADDR_W(10), .DATA_W(32), .WAIT_CYCLES(1)) dut (
      .clk(clk), .rst(rst), .req(req), .cs(cs), .we(we),
      .address(address), .data_in(data_in),
      .data_out(data_out1), .ack(ack1), .err(err1), .busy(busy1)
   );

   dmem_responder #(.ADDR_W(10), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .req(req), .cs(cs), .we(we),
      .address(address), .data_in(data_in),
      .data_out(data_out0), .ack(ack0), .err(err0), .busy(busy0)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Pulses req for one cycle and measures negedges until ack on the selected DUT;
   // returns one negedge after ack so both DUTs are back in IDLE-able state.
   task automatic txn(input bit zero, input logic w, input logic c, input logic [9:0] a,
                      input logic [31:0] d, input int exp_lat, input logic exp_err,
                      input string tag);
      int n;
      bit got;
      logic e;
      n = 0;
      got = 1'b0;
      e = 1'b0;
      req = 1'b1; cs = c; we = w; address = a; data_in = d;
      while (!got && n < 12) begin
         @(negedge clk);
         n++;
         if (n == 1) req = 1'b0;
         if (zero ? ack0 : ack1) begin
            got = 1'b1;
            e = zero ? err0 : err1;
         end
      end
      chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
      chk({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
      @(negedge clk);
   endtask

   initial begin
      // reset state
      @(negedge clk);
      chk("rst_ack",  {31'd0, ack1}, 32'd0);
      chk("rst_err",  {31'd0, err1}, 32'd0);
      chk("rst_busy", {31'd0, busy1}, 32'd0);
      chk("rst_dout", data_out1, 32'd0);
      chk("rst_busy0", {31'd0, busy0}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // aborted write: reset during WAIT must suppress the RAM write
      txn(1'b0, 1'b1, 1'b1, 10'h005, 32'h11111111, 3, 1'b0, "pre_wr5");
      req = 1'b1; cs = 1'b1; we = 1'b1; address = 10'h005; data_in = 32'hDEADBEEF;
      @(negedge clk);
      req = 1'b0;
      chk("abort_busy_pre", {31'd0, busy1}, 32'd1);
      rst = 1'b1;
      #1;
      chk("abort_busy_rst", {31'd0, busy1}, 32'd0);
      chk("abort_ack_rst",  {31'd0, ack1}, 32'd0);
      chk("abort_err_rst",  {31'd0, err1}, 32'd0);
      chk("abort_dout_rst", data_out1, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      txn(1'b0, 1'b0, 1'b1, 10'h005, 32'h0, 3, 1'b0, "rd5");
      chk("rd5_data", data_out1, 32'h11111111);

      // write then read
      txn(1'b0, 1'b1, 1'b1, 10'h000, 32'hCAFEF00D, 3, 1'b0, "wr0");
      chk("wr0_dout_hold", data_out1, 32'h11111111);
      txn(1'b0, 1'b0, 1'b1, 10'h000, 32'h0, 3, 1'b0, "rd0");
      chk("rd0_data", data_out1, 32'hCAFEF00D);

      // top address
      txn(1'b0, 1'b1, 1'b1, 10'h3FF, 32'h12345678, 3, 1'b0, "wr3ff");
      txn(1'b0, 1'b0, 1'b1, 10'h3FF, 32'h0, 3, 1'b0, "rd3ff");
      chk("rd3ff_data", data_out1, 32'h12345678);
      txn(1'b0, 1'b0, 1'b1, 10'h000, 32'h0, 3, 1'b0, "rd0b");
      chk("rd0b_data", data_out1, 32'hCAFEF00D);

      // out-of-range write
      req = 1'b1; cs = 1'b0; we = 1'b1; address = 10'h000; data_in = 32'h0BAD0BAD;
      @(negedge clk);
      req = 1'b0;
      chk("oor_ack",  {31'd0, ack1}, 32'd1);
      chk("oor_err",  {31'd0, err1}, 32'd1);
      chk("oor_busy", {31'd0, busy1}, 32'd1);
      @(negedge clk);
      chk("oor_busy_after", {31'd0, busy1}, 32'd0);
      chk("oor_ack_after",  {31'd0, ack1}, 32'd0);
      chk("oor_dout", data_out1, 32'hCAFEF00D);
      txn(1'b0, 1'b0, 1'b0, 10'h3FF, 32'h0, 1, 1'b1, "oor_rd");
      chk("oor_rd_dout", data_out1, 32'hCAFEF00D);
      txn(1'b0, 1'b0, 1'b1, 10'h000, 32'h0, 3, 1'b0, "rd0c");
      chk("rd0c_data", data_out1, 32'hCAFEF00D);

      // held request with inputs glitching while busy
      req = 1'b1; cs = 1'b1; we = 1'b1; address = 10'h0A0; data_in = 32'hA5A5A5A5;
      @(negedge clk);
      chk("hold_busy1", {31'd0, busy1}, 32'd1);
      we = 1'b0; address = 10'h0B0; data_in = 32'hFFFFFFFF; cs = 1'b0;
      @(negedge clk);
      chk("hold_ack2", {31'd0, ack1}, 32'd0);
      @(negedge clk);
      chk("hold_ack3", {31'd0, ack1}, 32'd1);
      chk("hold_err3", {31'd0, err1}, 32'd0);
      @(negedge clk);
      chk("hold_idle", {31'd0, busy1}, 32'd0);
      cs = 1'b1; we = 1'b0; address = 10'h0A0;
      @(negedge clk);
      chk("hold_reaccept", {31'd0, busy1}, 32'd1);
      req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("hold_rd_ack", {31'd0, ack1}, 32'd1);
      chk("hold_rd_data", data_out1, 32'hA5A5A5A5);
      repeat (3) @(negedge clk);

      // zero wait states
      txn(1'b1, 1'b1, 1'b1, 10'h010, 32'h0BADF00D, 2, 1'b0, "z_wr");
      repeat (3) @(negedge clk);
      txn(1'b1, 1'b0, 1'b1, 10'h010, 32'h0, 2, 1'b0, "z_rd");
      chk("z_rd_data", data_out0, 32'h0BADF00D);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width of the decoded address.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 Parameter WAIT_CYCLES, default 1, wait states inserted before each memory access; range 0..15.
REQ-004 Port clk  input  1  system clock; all state changes on its rising edge.
REQ-005 Port rst  input  1  reset, asynchronous and active-high.
REQ-006 Port req  input  1  access request strobe from the CPU side.
REQ-007 Port cs  input  1  chip select from the address decoder; 1 means the address is in range.
REQ-008 Port we  input  1  write enable from the address decoder; 1 means write, 0 means read.
REQ-009 Port address  input  ADDR_W  decoded word address.
REQ-010 Port data_in  input  DATA_W  write data.
REQ-011 Port data_out  output  DATA_W  read data, registered.
REQ-012 Port ack  output  1  one-cycle completion pulse.
REQ-013 Port err  output  1  one-cycle pulse, coincident with ack, for an out-of-range request.
REQ-014 Port busy  output  1  high whenever the block is not in IDLE.

Function
REQ-015 The FSM SHALL have four states: IDLE, WAIT, ACCESS and ACK.
REQ-016 In IDLE, req=1 at a rising edge SHALL latch address, data_in and we, and SHALL accept the request.
REQ-017 In IDLE, req=1 with cs=1 SHALL go to WAIT with the counter loaded to WAIT_CYCLES; if WAIT_CYCLES=0, it SHALL go directly to ACCESS.
REQ-018 In WAIT, the counter SHALL decrement on each edge and SHALL move to ACCESS on the edge where the counter equals 1.
REQ-019 The ACCESS edge SHALL write the latched data to RAM for a write, or load the RAM word into data_out for a read, and SHALL then move to ACK.
REQ-020 In ACK, ack SHALL be 1 for exactly one cycle, and the next edge SHALL return the FSM to IDLE.
REQ-021 With acceptance at edge N, ack SHALL be high in the cycle after edge N+WAIT_CYCLES+1, giving a total latency of WAIT_CYCLES+2 cycles.
REQ-022 In IDLE, req=1 with cs=0 SHALL go straight to ACK with err=1, with no RAM write and data_out unchanged.
REQ-023 Changes on req, cs, we, address and data_in while busy=1 SHALL be ignored, with no queuing.
REQ-024 req held high through ACK SHALL be re-accepted only at the first edge in IDLE, giving a minimum request spacing of WAIT_CYCLES+3 cycles.
REQ-025 data_out SHALL hold its value until the next read reaches ACCESS; writes and err accesses SHALL NOT change data_out.
REQ-026 Address arithmetic SHALL be ADDR_W bits with no wrap logic, and all 2^ADDR_W words SHALL be addressable.
REQ-027 ack and err SHALL be 0 in every state other than ACK.

Reset
REQ-028 rst=1 SHALL force, asynchronously, state=IDLE, counter=0, data_out=0, ack=0, err=0 and busy=0.
REQ-029 Reset asserted before the ACCESS edge SHALL abort the access with no RAM write.
REQ-030 RAM contents SHALL NOT be cleared by reset.

Structure
REQ-031 The state encoding, the WAIT_CYCLES bound and the default widths SHALL be defined in the shared CPU package/include file.
REQ-032 Storage SHALL be one sub-module, dmem_ram: 2^ADDR_W x DATA_W, synchronous write, registered read; dmem_responder SHALL contain only the FSM, counter and latches.

Verification
REQ-033 Reset and idle: with rst pulsed mid-WAIT during a write of 32'hDEADBEEF to 10'h005, a later read of 10'h005 SHALL NOT return DEADBEEF, and all outputs SHALL be 0 during reset.
REQ-034 Write then read: WAIT_CYCLES=1, write 32'hCAFEF00D to 10'h000, then read 10'h000 -> ack 3 cycles after each acceptance, data_out=32'hCAFEF00D, err=0.
REQ-035 Boundary address: write then read 10'h3FF with 32'h12345678 -> correct data, and address 10'h000 SHALL be unaffected.
REQ-036 Out-of-range request: req=1, cs=0, we=1 -> ack=err=1 on the next cycle, busy high for 1 cycle, RAM unchanged, data_out unchanged.
REQ-037 Held request and input glitching: req held high with address changed mid-WAIT -> the originally latched address SHALL be accessed, and the next acceptance SHALL occur in the cycle after ack.
REQ-038 Zero wait: WAIT_CYCLES=0, read -> ack 2 cycles after acceptance.
